// File: rtl/reg_scoreboard_if.sv
// Issue/retire/jump handshake bundle between fetch_unit and reg_scoreboard.
// master = fetch/pipeline side driving events, slave = scoreboard reporting hazards.
interface reg_scoreboard_if #(
  parameter int NREG = 32
);
  logic            issue_valid;
  logic            issue_we;
  logic [4:0]      issue_rd;
  logic            issue_jmp;
  logic            wb_valid;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic            jmp_resolve;
  logic            flush;
  logic [NREG-1:0] busy_reg;
  logic            jmp_op_in_pipeline;
  logic            issue_ready;
  logic            drained;
  logic            fault;
  logic [1:0]      fault_code;

  modport master (
    output issue_valid, issue_we, issue_rd, issue_jmp,
    output wb_valid, wb_we, wb_rd, jmp_resolve, flush,
    input  busy_reg, jmp_op_in_pipeline, issue_ready, drained, fault, fault_code
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_jmp,
    input  wb_valid, wb_we, wb_rd, jmp_resolve, flush,
    output busy_reg, jmp_op_in_pipeline, issue_ready, drained, fault, fault_code
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Destination-register hazard scoreboard: one-cycle state update, issue_ready throttles issue on
// in-flight limit or pending jump. SCOREBOARD_BYPASS_EN enables same-cycle release of retiring rd.
module reg_scoreboard #(
  parameter int NREG         = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave sb
);
  localparam logic [0:0]       ST_IDLE     = 1'b0;
  localparam logic [0:0]       ST_JMP_PEND = 1'b1;
  localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [NREG-1:0]  ONE_HOT0    = NREG'(1);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [0:0]       jmp_st_q, jmp_st_d;
  logic             fault_q, fault_d;
  logic [1:0]       fault_code_q, fault_code_d;

  logic            room;
  logic            issue_rdy;
  logic            issue_acc;
  logic            issue_ovf;
  logic            retire;
  logic            wb_empty;
  logic            wb_clr_en;
  logic            wb_dbl;
  logic            resolve_ok;
  logic            resolve_stray;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [1:0]      evt_code;

  always_comb begin
`ifdef SCOREBOARD_BYPASS_EN
    // A retire in this cycle frees a slot for the instr issuing alongside it.
    room = (inflight_q < MAX_CNT) || sb.wb_valid;
`else
    room = (inflight_q < MAX_CNT);
`endif
    issue_rdy     = room && (jmp_st_q == ST_IDLE);
    issue_acc     = sb.issue_valid && issue_rdy;
    issue_ovf     = sb.issue_valid && !issue_rdy;
    wb_empty      = sb.wb_valid && (inflight_q == '0);
    retire        = sb.wb_valid && (inflight_q != '0);
    wb_clr_en     = retire && sb.wb_we && (sb.wb_rd != 5'd0);
    wb_dbl        = wb_clr_en && !busy_q[sb.wb_rd];
    resolve_ok    = sb.jmp_resolve && (jmp_st_q == ST_JMP_PEND);
    resolve_stray = sb.jmp_resolve && (jmp_st_q == ST_IDLE);

    set_mask = (issue_acc && sb.issue_we && (sb.issue_rd != 5'd0)) ? (ONE_HOT0 << sb.issue_rd) : '0;
    clr_mask = wb_clr_en ? (ONE_HOT0 << sb.wb_rd) : '0;
  end

  // Simultaneous faults resolve to the lowest code; flush suppresses all of them.
  always_comb begin
    evt_code = 2'd0;
    if (!sb.flush) begin
      if (issue_ovf) begin
        evt_code = 2'd1;
      end else if (wb_empty || wb_dbl) begin
        evt_code = 2'd2;
      end else if (resolve_stray) begin
        evt_code = 2'd3;
      end
    end
    fault_d      = fault_q || (evt_code != 2'd0);
    fault_code_d = fault_q ? fault_code_q : evt_code;
  end

  always_comb begin
    busy_d     = busy_q;
    inflight_d = inflight_q;
    jmp_st_d   = jmp_st_q;
    if (sb.flush) begin
      busy_d     = '0;
      inflight_d = '0;
      jmp_st_d   = ST_IDLE;
    end else begin
      // Clear before set so a same-cycle reissue of the retiring rd keeps it busy.
      busy_d    = (busy_q & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;
      case ({issue_acc, retire})
        2'b10:   inflight_d = inflight_q + CNT_ONE;
        2'b01:   inflight_d = inflight_q - CNT_ONE;
        default: inflight_d = inflight_q;
      endcase
      if (issue_acc && sb.issue_jmp) begin
        jmp_st_d = ST_JMP_PEND;
      end else if (resolve_ok) begin
        jmp_st_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      inflight_q   <= '0;
      jmp_st_q     <= ST_IDLE;
      fault_q      <= 1'b0;
      fault_code_q <= 2'd0;
    end else begin
      busy_q       <= busy_d;
      inflight_q   <= inflight_d;
      jmp_st_q     <= jmp_st_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

`ifdef SCOREBOARD_BYPASS_EN
  logic [NREG-1:0] wb_mask;
  always_comb begin
    wb_mask = (sb.wb_valid && sb.wb_we && !sb.flush) ? (ONE_HOT0 << sb.wb_rd) : '0;
  end
  assign sb.busy_reg = busy_q & ~wb_mask;
`else
  assign sb.busy_reg = busy_q;
`endif

  assign sb.issue_ready        = issue_rdy;
  assign sb.drained            = (inflight_q == '0) && (jmp_st_q == ST_IDLE);
  assign sb.jmp_op_in_pipeline = (jmp_st_q == ST_JMP_PEND);
  assign sb.fault              = fault_q;
  assign sb.fault_code         = fault_code_q;
endmodule
